// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM with RISC-V load/store width rules, one outstanding request.
// Defining DATA_MEM_PERF_CNT_EN adds load/store/error/stall counters.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 16384,
    parameter int LATENCY     = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
`ifdef DATA_MEM_PERF_CNT_EN
    ,
    output logic [31:0] load_count,
    output logic [31:0] store_count,
    output logic [31:0] err_count,
    output logic [31:0] stall_count
`endif
);
    localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_EXEC, ST_RESP} state_t;
    state_t state, state_nxt;

    logic [3:0]    cnt;
    logic          wr_q;
    logic [2:0]    f3_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   mem [DEPTH_WORDS];

    logic          misalign, out_of_range, illegal, err;
    logic [IW-1:0] widx;
    logic [31:0]   word, load_val, wd;
    logic [7:0]    lbyte;
    logic [15:0]   lhalf;
    logic [3:0]    be;

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = (LATENCY == 0) ? ST_EXEC : ST_WAIT;
            end
            ST_WAIT: if (cnt <= 4'd1) state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_RESP;
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Access decode works off the latched request, so it is only meaningful in EXEC.
    always_comb begin
        misalign     = (f3_q[1:0] == 2'b01 && addr_q[0]) ||
                       (f3_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00);
        out_of_range = {2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS);
        illegal      = wr_q ? (f3_q[2] || f3_q[1:0] == 2'b11)
                            : (f3_q == 3'b011 || f3_q[2:1] == 2'b11);
        err          = misalign | out_of_range | illegal;
        widx         = addr_q[IW+1:2];
        word         = mem[widx];
        case (addr_q[1:0])
            2'b00:   lbyte = word[7:0];
            2'b01:   lbyte = word[15:8];
            2'b10:   lbyte = word[23:16];
            default: lbyte = word[31:24];
        endcase
        lhalf = addr_q[1] ? word[31:16] : word[15:0];
        case (f3_q)
            3'b000:  load_val = {{24{lbyte[7]}}, lbyte};
            3'b001:  load_val = {{16{lhalf[15]}}, lhalf};
            3'b010:  load_val = word;
            3'b100:  load_val = {24'h0, lbyte};
            3'b101:  load_val = {16'h0, lhalf};
            default: load_val = 32'h0;
        endcase
        be = 4'b0000;
        wd = wdata_q;
        case (f3_q[1:0])
            2'b00: begin be = 4'b0001 << addr_q[1:0]; wd = {4{wdata_q[7:0]}}; end
            2'b01: begin be = addr_q[1] ? 4'b1100 : 4'b0011; wd = {2{wdata_q[15:0]}}; end
            2'b10: be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_n && state == ST_EXEC && wr_q && !err) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[widx][8*b +: 8] <= wd[8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            cnt        <= 4'd0;
            wr_q       <= 1'b0;
            f3_q       <= 3'b000;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: if (req_valid) begin
                    wr_q    <= req_write;
                    f3_q    <= req_funct3;
                    addr_q  <= req_addr;
                    wdata_q <= req_wdata;
                    cnt     <= 4'(LATENCY);
                end
                ST_WAIT: cnt <= cnt - 4'd1;
                ST_EXEC: begin
                    resp_err   <= err;
                    resp_rdata <= (wr_q || err) ? 32'h0 : load_val;
                end
                ST_RESP: if (resp_ready) begin
                    resp_rdata <= 32'h0;
                    resp_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef DATA_MEM_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            load_count  <= 32'h0;
            store_count <= 32'h0;
            err_count   <= 32'h0;
            stall_count <= 32'h0;
        end else begin
            if (state == ST_IDLE && req_valid && !req_write) load_count <= load_count + 32'h1;
            if (state == ST_EXEC && wr_q && !err) store_count <= store_count + 32'h1;
            if (state == ST_EXEC && err) err_count <= err_count + 32'h1;
            if (req_valid && !req_ready) stall_count <= stall_count + 32'h1;
        end
    end
`endif
endmodule
